// File: rtl/modulation_timer_iter_if.sv
// Settings/time inputs and index outputs of modulation_timer_iter.
// MOD_TIMER_PHASE_OFFSET_EN adds the per-segment phase_offset_i field.
interface modulation_timer_iter_if #(
  parameter int unsigned NUM_SEGMENT    = 2,
  parameter int unsigned CYCLE_WIDTH    = 15,
  parameter int unsigned FREQ_DIV_WIDTH = 16
);
  logic [63:0]                                 sys_time_i;
  logic                                        update_settings_in_i;
  logic [NUM_SEGMENT-1:0][CYCLE_WIDTH-1:0]     cycle_i;
  logic [NUM_SEGMENT-1:0][FREQ_DIV_WIDTH-1:0]  freq_div_i;
`ifdef MOD_TIMER_PHASE_OFFSET_EN
  logic [NUM_SEGMENT-1:0][CYCLE_WIDTH-1:0]     phase_offset_i;
`endif
  logic [NUM_SEGMENT-1:0][CYCLE_WIDTH-1:0]     idx_o;
  logic                                        idx_valid_o;
  logic                                        update_settings_out_o;
  logic                                        busy_o;

  modport master (
    output sys_time_i, update_settings_in_i, cycle_i, freq_div_i,
`ifdef MOD_TIMER_PHASE_OFFSET_EN
    output phase_offset_i,
`endif
    input  idx_o, idx_valid_o, update_settings_out_o, busy_o
  );

  modport slave (
    input  sys_time_i, update_settings_in_i, cycle_i, freq_div_i,
`ifdef MOD_TIMER_PHASE_OFFSET_EN
    input  phase_offset_i,
`endif
    output idx_o, idx_valid_o, update_settings_out_o, busy_o
  );
endinterface

// File: rtl/modulation_timer_iter.sv
// Per-segment modulation index: floor(t / freq_div) mod (cycle+1), lockstep 1-bit/clk dividers.
// Optional feature macro: MOD_TIMER_PHASE_OFFSET_EN (per-segment phase offset added at commit).
module modulation_timer_iter #(
  parameter int unsigned NUM_SEGMENT    = 2,
  parameter int unsigned TIME_SHIFT     = 8,
  parameter int unsigned CYCLE_WIDTH    = 15,
  parameter int unsigned FREQ_DIV_WIDTH = 16
) (
  input logic                    clk,
  input logic                    rst_n,
  modulation_timer_iter_if.slave bus_if
);
  localparam int unsigned DW   = 64 - TIME_SHIFT;
  localparam int unsigned FDW  = FREQ_DIV_WIDTH;
  localparam int unsigned CLW  = CYCLE_WIDTH + 1;
  localparam int unsigned RW   = (FDW > CLW) ? FDW : CLW;
  localparam int unsigned TW   = RW + 1;
  localparam int unsigned SW   = CLW + 1;
  localparam int unsigned CNTW = $clog2(DW);

  typedef enum logic [1:0] {S_IDLE, S_DIV_Q, S_DIV_R, S_COMMIT} state_e;

  state_e                                 state_q, state_d;
  logic                                   pending_q, pending_d;
  logic                                   upd_tag_q, upd_tag_d;
  logic                                   t_valid_q, t_valid_d;
  logic [DW-1:0]                          t_last_q, t_last_d;
  logic [CNTW-1:0]                        cnt_q, cnt_d;
  logic [NUM_SEGMENT-1:0][CYCLE_WIDTH-1:0] sh_cycle_q, sh_cycle_d;
  logic [NUM_SEGMENT-1:0][FDW-1:0]        sh_fdiv_q, sh_fdiv_d;
  logic [NUM_SEGMENT-1:0][FDW-1:0]        act_fdiv_q, act_fdiv_d;
  logic [NUM_SEGMENT-1:0][CLW-1:0]        act_clen_q, act_clen_d;
  logic [NUM_SEGMENT-1:0][DW-1:0]         quo_q, quo_d;
  logic [NUM_SEGMENT-1:0][RW-1:0]         rem_q, rem_d;
  logic [NUM_SEGMENT-1:0][CYCLE_WIDTH-1:0] idx_q, idx_d;
  logic                                   idx_valid_q, idx_valid_d;
  logic                                   upd_out_q, upd_out_d;
  logic                                   busy_q, busy_d;
`ifdef MOD_TIMER_PHASE_OFFSET_EN
  logic [NUM_SEGMENT-1:0][CYCLE_WIDTH-1:0] sh_off_q, sh_off_d;
  logic [NUM_SEGMENT-1:0][CYCLE_WIDTH-1:0] act_off_q, act_off_d;
`endif

  logic [DW-1:0] t_cur_c;
  assign t_cur_c = DW'(bus_if.sys_time_i >> TIME_SHIFT);

  // Next-state: settings shadowing, start decision, shared restoring-divide step, commit
  always_comb begin
    logic [TW-1:0] trial;
    logic [TW-1:0] dvs;
    logic [SW-1:0] sum;
    logic          load;
    state_d     = state_q;
    pending_d   = pending_q;
    upd_tag_d   = upd_tag_q;
    t_valid_d   = t_valid_q;
    t_last_d    = t_last_q;
    cnt_d       = cnt_q;
    sh_cycle_d  = sh_cycle_q;
    sh_fdiv_d   = sh_fdiv_q;
    act_fdiv_d  = act_fdiv_q;
    act_clen_d  = act_clen_q;
    quo_d       = quo_q;
    rem_d       = rem_q;
    idx_d       = idx_q;
    idx_valid_d = idx_valid_q;
    upd_out_d   = 1'b0;
    trial       = '0;
    dvs         = '0;
    sum         = '0;
    load        = 1'b0;
`ifdef MOD_TIMER_PHASE_OFFSET_EN
    sh_off_d    = sh_off_q;
    act_off_d   = act_off_q;
`endif

    if (bus_if.update_settings_in_i) begin
      sh_cycle_d = bus_if.cycle_i;
      sh_fdiv_d  = bus_if.freq_div_i;
`ifdef MOD_TIMER_PHASE_OFFSET_EN
      sh_off_d   = bus_if.phase_offset_i;
`endif
    end

    case (state_q)
      S_IDLE: begin
        if (pending_q || !t_valid_q || (t_cur_c != t_last_q)) begin
          state_d   = S_DIV_Q;
          t_last_d  = t_cur_c;
          t_valid_d = 1'b1;
          cnt_d     = '0;
          for (int s = 0; s < NUM_SEGMENT; s++) begin
            quo_d[s] = t_cur_c;
            rem_d[s] = '0;
          end
          if (pending_q) begin
            load      = 1'b1;
            upd_tag_d = 1'b1;
            for (int s = 0; s < NUM_SEGMENT; s++) begin
              act_fdiv_d[s] = (sh_fdiv_q[s] == '0) ? FDW'(1) : sh_fdiv_q[s];
              act_clen_d[s] = CLW'(sh_cycle_q[s]) + CLW'(1);
`ifdef MOD_TIMER_PHASE_OFFSET_EN
              act_off_d[s]  = (sh_off_q[s] > sh_cycle_q[s]) ? '0 : sh_off_q[s];
`endif
            end
          end
        end
      end
      S_DIV_Q, S_DIV_R: begin
        // Quotient bits shift into quo; after DIV_R, rem holds q mod cycle_len
        for (int s = 0; s < NUM_SEGMENT; s++) begin
          dvs   = (state_q == S_DIV_Q) ? TW'(act_fdiv_q[s]) : TW'(act_clen_q[s]);
          trial = {rem_q[s], quo_q[s][DW-1]};
          if (trial >= dvs) begin
            rem_d[s] = RW'(trial - dvs);
            quo_d[s] = {quo_q[s][DW-2:0], 1'b1};
          end else begin
            rem_d[s] = RW'(trial);
            quo_d[s] = {quo_q[s][DW-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(DW - 1)) begin
          cnt_d = '0;
          if (state_q == S_DIV_Q) begin
            state_d = S_DIV_R;
            rem_d   = '0;
          end else begin
            state_d = S_COMMIT;
          end
        end
      end
      S_COMMIT: begin
        for (int s = 0; s < NUM_SEGMENT; s++) begin
`ifdef MOD_TIMER_PHASE_OFFSET_EN
          sum = SW'(rem_q[s]) + SW'(act_off_q[s]);
          if (sum >= SW'(act_clen_q[s])) sum = sum - SW'(act_clen_q[s]);
          idx_d[s] = CYCLE_WIDTH'(sum);
`else
          idx_d[s] = CYCLE_WIDTH'(rem_q[s]);
`endif
        end
        idx_valid_d = 1'b1;
        upd_out_d   = upd_tag_q;
        upd_tag_d   = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A settings pulse in the start cycle stays pending for the following run
    if (bus_if.update_settings_in_i) pending_d = 1'b1;
    else if (load)                   pending_d = 1'b0;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pending_q   <= 1'b0;
      upd_tag_q   <= 1'b0;
      t_valid_q   <= 1'b0;
      t_last_q    <= '0;
      cnt_q       <= '0;
      sh_cycle_q  <= '0;
      sh_fdiv_q   <= '0;
      act_fdiv_q  <= {NUM_SEGMENT{FDW'(1)}};
      act_clen_q  <= {NUM_SEGMENT{CLW'(1)}};
      quo_q       <= '0;
      rem_q       <= '0;
      idx_q       <= '0;
      idx_valid_q <= 1'b0;
      upd_out_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef MOD_TIMER_PHASE_OFFSET_EN
      sh_off_q    <= '0;
      act_off_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      upd_tag_q   <= upd_tag_d;
      t_valid_q   <= t_valid_d;
      t_last_q    <= t_last_d;
      cnt_q       <= cnt_d;
      sh_cycle_q  <= sh_cycle_d;
      sh_fdiv_q   <= sh_fdiv_d;
      act_fdiv_q  <= act_fdiv_d;
      act_clen_q  <= act_clen_d;
      quo_q       <= quo_d;
      rem_q       <= rem_d;
      idx_q       <= idx_d;
      idx_valid_q <= idx_valid_d;
      upd_out_q   <= upd_out_d;
      busy_q      <= busy_d;
`ifdef MOD_TIMER_PHASE_OFFSET_EN
      sh_off_q    <= sh_off_d;
      act_off_q   <= act_off_d;
`endif
    end
  end

  assign bus_if.idx_o                 = idx_q;
  assign bus_if.idx_valid_o           = idx_valid_q;
  assign bus_if.update_settings_out_o = upd_out_q;
  assign bus_if.busy_o                = busy_q;
endmodule

// File: tb/tb_modulation_timer_iter.sv
// Directed bench for modulation_timer_iter with hand-computed indices.
// Phase-offset vectors run only when MOD_TIMER_PHASE_OFFSET_EN is defined.
module tb_modulation_timer_iter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  int   upd_cnt;
  logic [14:0] upd_idx0;
  logic [14:0] upd_prev0;
  logic [14:0] prev0;
  int   upd_cnt_ref;

  modulation_timer_iter_if #(.NUM_SEGMENT(2), .CYCLE_WIDTH(15), .FREQ_DIV_WIDTH(16)) bus ();

  modulation_timer_iter #(
    .NUM_SEGMENT(2), .TIME_SHIFT(8), .CYCLE_WIDTH(15), .FREQ_DIV_WIDTH(16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records each settings-applied pulse with the index before and at that clock
  always @(posedge clk) begin
    #1;
    if (bus.update_settings_out_o) begin
      upd_cnt   = upd_cnt + 1;
      upd_idx0  = bus.idx_o[0];
      upd_prev0 = prev0;
    end
    prev0 = bus.idx_o[0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic apply_settings(input logic [14:0] c0, input logic [15:0] f0, input logic [14:0] o0,
                                input logic [14:0] c1, input logic [15:0] f1, input logic [14:0] o1);
    bus.cycle_i[0]    = c0;
    bus.freq_div_i[0] = f0;
    bus.cycle_i[1]    = c1;
    bus.freq_div_i[1] = f1;
`ifdef MOD_TIMER_PHASE_OFFSET_EN
    bus.phase_offset_i[0] = o0;
    bus.phase_offset_i[1] = o1;
`else
    if (o0 != o1) begin end
`endif
    bus.update_settings_in_i = 1'b1;
    @(negedge clk);
    bus.update_settings_in_i = 1'b0;
  endtask

  task automatic set_t(input logic [55:0] t);
    bus.sys_time_i = {t, 8'h00};
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!bus.busy_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_rise"}, 64'(bus.busy_o), 64'd1);
    n = 0;
    while (bus.busy_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy_fall"}, 64'(bus.busy_o), 64'd0);
  endtask

  task automatic check_idx(input string tag, input logic [14:0] e0, input logic [14:0] e1);
    check({tag, "_idx0"}, 64'(bus.idx_o[0]), 64'(e0));
    check({tag, "_idx1"}, 64'(bus.idx_o[1]), 64'(e1));
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    upd_cnt  = 0;
    prev0    = '0;
    upd_idx0 = '0;
    upd_prev0 = '0;
    rst_n    = 1'b0;
    bus.sys_time_i           = '0;
    bus.update_settings_in_i = 1'b0;
    bus.cycle_i              = '0;
    bus.freq_div_i           = '0;
`ifdef MOD_TIMER_PHASE_OFFSET_EN
    bus.phase_offset_i       = '0;
`endif
    repeat (3) @(negedge clk);
    check("rst_idx0", 64'(bus.idx_o[0]), 64'd0);
    check("rst_valid", 64'(bus.idx_valid_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_upd", 64'(bus.update_settings_out_o), 64'd0);

    // 1: first computation forced after reset, 114 clocks to valid
    rst_n = 1'b1;
    n = 0;
    while (!bus.idx_valid_o && n < 300) begin
      @(negedge clk);
      n++;
      if (n == 1) check("t1_busy_next_clk", 64'(bus.busy_o), 64'd1);
    end
    check("t1_latency", 64'(n), 64'd114);
    check_idx("t1", 15'd0, 15'd0);
    check("t1_no_upd", 64'(upd_cnt), 64'd0);

    // 2: 1234/10 = 123 mod 100 = 23; 1234/7 = 176 mod 10 = 6
    apply_settings(15'd99, 16'd10, 15'd0, 15'd9, 16'd7, 15'd0);
    set_t(56'd1234);
    wait_done("t2");
    check_idx("t2", 15'd23, 15'd6);
    check("t2_upd_cnt", 64'(upd_cnt), 64'd1);
    check("t2_upd_idx", 64'(upd_idx0), 64'd23);
    check("t2_upd_prev_idx", 64'(upd_prev0), 64'd0);

    // 3: cycle_len 4, freq_div 1 and 2, then both 0 (treated as 1)
    apply_settings(15'd3, 16'd1, 15'd0, 15'd3, 16'd2, 15'd0);
    set_t(56'd7);
    wait_done("t3a");
    check_idx("t3a", 15'd3, 15'd3);
    set_t(56'd8);
    wait_done("t3b");
    check_idx("t3b", 15'd0, 15'd0);
    apply_settings(15'd3, 16'd0, 15'd0, 15'd3, 16'd0, 15'd0);
    set_t(56'd7);
    wait_done("t3c");
    check_idx("t3c", 15'd3, 15'd3);
    set_t(56'd8);
    wait_done("t3d");
    check_idx("t3d", 15'd0, 15'd0);
    upd_cnt_ref = upd_cnt;

    // 4: settings pulse mid DIV_Q: old commit 100 mod 4 = 0, new 100/10 mod 100 = 10, 100/3 mod 5 = 3
    set_t(56'd100);
    repeat (10) @(negedge clk);
    apply_settings(15'd99, 16'd10, 15'd0, 15'd4, 16'd3, 15'd0);
    wait_done("t4_old");
    check_idx("t4_old", 15'd0, 15'd0);
    check("t4_old_no_upd", 64'(upd_cnt), 64'(upd_cnt_ref));
    wait_done("t4_new");
    check_idx("t4_new", 15'd10, 15'd3);
    check("t4_new_upd", 64'(upd_cnt), 64'(upd_cnt_ref + 1));
    repeat (5) @(negedge clk);
    check("t4_stays_idle", 64'(bus.busy_o), 64'd0);

    // 5: t = 2^56-1: mod 2^15 = 32767; /65535 = 2^40+2^24+2^8, mod 2^15 = 256
    apply_settings(15'd32767, 16'd1, 15'd0, 15'd32767, 16'hFFFF, 15'd0);
    set_t(56'hFF_FFFF_FFFF_FFFF);
    wait_done("t5");
    check_idx("t5", 15'd32767, 15'd256);
    upd_cnt_ref = upd_cnt;
    set_t(56'd5);
    repeat (66) @(negedge clk);
    apply_settings(15'd9, 16'd1, 15'd0, 15'd9, 16'd1, 15'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_idx0", 64'(bus.idx_o[0]), 64'd0);
    check("t5_rst_idx1", 64'(bus.idx_o[1]), 64'd0);
    check("t5_rst_valid", 64'(bus.idx_valid_o), 64'd0);
    check("t5_rst_busy", 64'(bus.busy_o), 64'd0);
    check("t5_rst_upd", 64'(bus.update_settings_out_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_done("t5_post");
    // pending settings dropped by reset: defaults give 5 mod 1 = 0 and no pulse
    check_idx("t5_post", 15'd0, 15'd0);
    check("t5_post_valid", 64'(bus.idx_valid_o), 64'd1);
    check("t5_post_no_upd", 64'(upd_cnt), 64'(upd_cnt_ref));

`ifdef MOD_TIMER_PHASE_OFFSET_EN
    // 6: r = 7 mod 10; offset 5 -> 2; offset 12 > 9 -> ignored -> 7
    apply_settings(15'd9, 16'd1, 15'd5, 15'd9, 16'd1, 15'd12);
    set_t(56'd7);
    wait_done("t6");
    check_idx("t6", 15'd2, 15'd7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
